// File: rtl/escalonador_rr.sv
// escalonador_rr -- round-robin scheduler in front of the 4-source router.
//
// Watches the request lines of the data sources and drives the router
// select. A grant is held stable until the downstream consumer accepts the
// word. The granted source then receives a one-cycle acknowledge, and a
// running transfer count is incremented.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req        per-source request (bit i = source i holds a valid word)
//   out_ready  downstream accepts the router output this cycle
//   sel        registered router select
//   out_valid  router output carries a granted word
//   ack        registered one-hot acknowledge, one cycle after acceptance
//   count      completed transfers, modulo 2**CW
module escalonador_rr #(
  parameter int SEL_BITS = 2,
  parameter int CW       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [(2**SEL_BITS)-1:0]   req,
  input  logic                       out_ready,
  output logic [SEL_BITS-1:0]        sel,
  output logic                       out_valid,
  output logic [(2**SEL_BITS)-1:0]   ack,
  output logic [CW-1:0]              count
);

  localparam int N = 2**SEL_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] sel_q, sel_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;
  logic [N-1:0]        ack_q, ack_d;
  logic [CW-1:0]       count_q, count_d;

  logic                hs;          // handshake completes on this edge
  logic [N-1:0]        sel_onehot;
  logic [N-1:0]        elig;
  logic [SEL_BITS-1:0] win;
  logic [SEL_BITS-1:0] idx;
  logic                found;

  assign hs         = (state_q == HOLD) && out_ready;
  assign sel_onehot = N'(1) << sel_q;

  // A source that is being accepted now, or that was acknowledged in the
  // previous cycle, may still hold req high; masking it prevents a second
  // grant of the same word.
  assign elig = req & ~ack_q & ~(hs ? sel_onehot : '0);

  // Rotating priority search starting at ptr_q; index arithmetic wraps
  // naturally at SEL_BITS width.
  // NOTE: every signal written in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_q + SEL_BITS'(k);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = win;
          ptr_d   = win + SEL_BITS'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Without out_ready the grant is frozen regardless of other requests.
        if (out_ready) begin
          ack_d   = sel_onehot;
          count_d = count_q + CW'(1);
          if (found) begin
            sel_d = win;
            ptr_d = win + SEL_BITS'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == HOLD);
  assign ack       = ack_q;
  assign count     = count_q;

endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: directed scenarios with expected
// values worked out from the scheduling rules, plus a randomized run checked
// cycle by cycle against a behavioural model.
module tb_escalonador_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [3:0] ack;
  logic [7:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int       m_sel, m_ptr, m_count;
  bit       m_valid;
  bit [3:0] m_ack;

  escalonador_rr #(.SEL_BITS(2), .CW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .ack       (ack),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advances the model using the inputs presented for this edge, then moves
  // past the edge so outputs can be sampled.
  task automatic tick();
    bit [3:0] e;
    bit       hs;
    int       w;
    if (reset) begin
      m_sel = 0; m_ptr = 0; m_count = 0; m_valid = 0; m_ack = '0;
    end else begin
      hs = m_valid && out_ready;
      e  = req & ~m_ack;
      if (hs) e[m_sel] = 1'b0;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && e[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      m_ack = hs ? 4'(1 << m_sel) : 4'b0;
      if (hs) m_count = (m_count + 1) % 256;
      if (!m_valid || hs) begin
        if (w >= 0) begin
          m_sel = w; m_valid = 1; m_ptr = (w + 1) % 4;
        end else begin
          m_valid = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; out_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({sel, out_valid, ack, count} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_state: got sel=%0d v=%b ack=%b cnt=%0d, want all zero",
               sel, out_valid, ack, count);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({sel, out_valid} !== {2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_grant: got sel=%0d v=%b, want sel=0 v=1", sel, out_valid);
    end
  endtask

  task automatic test_rotation();
    logic [14:0] exp_v;
    apply_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = {2'((k - 1) % 4), 1'b1,
               (k >= 2) ? 4'(1 << ((k - 2) % 4)) : 4'b0, 8'(k - 1)};
      n_cmp++;
      if ({sel, out_valid, ack, count} !== exp_v) begin
        n_err++;
        $display("FAIL rotation[%0d]: got %h want %h", k, {sel, out_valid, ack, count}, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req = 4'b0100; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req = {1'($urandom), 1'b1, 1'($urandom), 1'($urandom)};
      tick();
      n_cmp++;
      if ({sel, out_valid, ack, count} !== {2'd2, 1'b1, 4'b0000, 8'd0}) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got sel=%0d v=%b ack=%b cnt=%0d, want sel=2 v=1 ack=0000 cnt=0",
                 k, sel, out_valid, ack, count);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({ack, count} !== {4'b0100, 8'd1}) begin
      n_err++;
      $display("FAIL backpressure_release: got ack=%b cnt=%0d, want ack=0100 cnt=1", ack, count);
    end
    n_cmp++;
    if ({sel, out_valid} !== {2'(m_sel), m_valid}) begin
      n_err++;
      $display("FAIL backpressure_next: got sel=%0d v=%b, want sel=%0d v=%b",
               sel, out_valid, m_sel, m_valid);
    end
  endtask

  task automatic test_single_source();
    logic [14:0] exp_v [5];
    exp_v[0] = {2'd1, 1'b1, 4'b0000, 8'd0};
    exp_v[1] = {2'd1, 1'b0, 4'b0010, 8'd1};
    exp_v[2] = {2'd1, 1'b0, 4'b0000, 8'd1};  // masked cycle: no duplicate grant
    exp_v[3] = {2'd1, 1'b1, 4'b0000, 8'd1};
    exp_v[4] = {2'd1, 1'b0, 4'b0010, 8'd2};
    apply_reset();
    req = 4'b0010; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({sel, out_valid, ack, count} !== exp_v[k]) begin
        n_err++;
        $display("FAIL single_source[%0d]: got %h want %h", k, {sel, out_valid, ack, count}, exp_v[k]);
      end
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    req = 4'b1111; out_ready = 1'b1;
    tick();
    for (int k = 0; k < 255; k++) tick();
    n_cmp++;
    if (count !== 8'd255) begin
      n_err++;
      $display("FAIL count_255: got %0d want 255", count);
    end
    tick();
    n_cmp++;
    if (count !== 8'd0) begin
      n_err++;
      $display("FAIL count_wrap: got %0d want 0", count);
    end
  endtask

  task automatic test_mid_hold_reset();
    apply_reset();
    req = 4'b0010; out_ready = 1'b1;
    tick();                   // grant source 1, rotation pointer moves to 2
    tick();                   // handshake, back to idle, count=1
    req = 4'b1100; out_ready = 1'b0;
    tick();                   // grant source 2, hold under backpressure
    n_cmp++;
    if ({sel, out_valid, count} !== {2'd2, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL midhold_setup: got sel=%0d v=%b cnt=%0d, want sel=2 v=1 cnt=1",
               sel, out_valid, count);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({sel, out_valid, ack, count} !== 15'd0) begin
      n_err++;
      $display("FAIL midhold_reset: got sel=%0d v=%b ack=%b cnt=%0d, want all zero",
               sel, out_valid, ack, count);
    end
    reset = 1'b0; req = 4'b1111;
    tick();
    n_cmp++;
    if ({sel, out_valid} !== {2'd0, 1'b1}) begin
      n_err++;
      $display("FAIL midhold_ptr_restart: got sel=%0d v=%b, want sel=0 v=1", sel, out_valid);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 63) == 0);
      tick();
      n_cmp++;
      if ({sel, out_valid, ack, count} !== {2'(m_sel), m_valid, m_ack, 8'(m_count)}) begin
        n_err++;
        $display("FAIL random[%0d]: got sel=%0d v=%b ack=%b cnt=%0d, want sel=%0d v=%b ack=%b cnt=%0d",
                 k, sel, out_valid, ack, count, m_sel, m_valid, m_ack, m_count);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = '0; out_ready = 1'b0;
    m_sel = 0; m_ptr = 0; m_count = 0; m_valid = 0; m_ack = '0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_single_source();
    test_counter_wrap();
    test_mid_hold_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
